// File: rtl/axi_ram_slave.sv
// AXI4 responder RAM for cache refill/writeback bursts: INCR only, 32-bit beats,
// independent read and write FSMs over a simple dual-port synchronous RAM.
module axi_ram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_axi_awid,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Borrow out of the 33-bit subtract flags addresses below BASE_ADDR.
  function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic bad);
    logic [32:0] off;
    off = {1'b0, a & 32'hFFFF_FFFC} - {1'b0, BASE_ADDR};
    if (off[32] || off[31:0] >= SPAN) return DECERR;
    else if (bad)                     return SLVERR;
    else                              return OKAY;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return AW'(off >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  // ---------------- write channel ----------------
  logic [1:0]  w_state;
  logic        aw_rdy;
  logic [3:0]  w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_beat;
  logic        w_bad;
  logic [1:0]  w_resp, w_cur;
  logic        aw_hs, w_hs, b_hs, w_we;
  logic        unused_ok;

  assign unused_ok = s_axi_wlast;   // beat count alone terminates the burst

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bid     = w_id;
  assign s_axi_bresp   = w_resp;

  assign aw_hs = s_axi_awvalid & aw_rdy;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign b_hs  = s_axi_bvalid & s_axi_bready;
  assign w_cur = beat_resp(w_addr, w_bad);
  assign w_we  = w_hs && (w_cur == OKAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_rdy  <= 1'b0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_bad   <= 1'b0;
      w_resp  <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          aw_rdy <= 1'b1;
          if (aw_hs) begin
            aw_rdy  <= 1'b0;
            w_id    <= s_axi_awid;
            w_addr  <= s_axi_awaddr;
            w_len   <= s_axi_awlen;
            w_bad   <= (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'b010);
            w_beat  <= '0;
            w_resp  <= OKAY;
            w_state <= W_DATA;
          end
        end
        W_DATA: if (w_hs) begin
          // Encoding order makes the numeric max the worst response.
          if (w_cur > w_resp) w_resp <= w_cur;
          if (w_beat == w_len) begin
            w_state <= W_RESP;
          end else begin
            w_beat <= w_beat + 8'd1;
            w_addr <= w_addr + 32'd4;
          end
        end
        W_RESP: if (b_hs) begin
          aw_rdy  <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  logic [0:0]  r_state;
  logic        ar_rdy;
  logic [3:0]  r_id;
  logic [31:0] r_addr, r_next;
  logic [7:0]  r_len, r_beat;
  logic        r_bad, ar_bad;
  logic [1:0]  r_resp;
  logic [31:0] r_q;
  logic        ar_hs, r_hs, r_last, rd_en;
  logic [AW-1:0] rd_idx;

  assign ar_bad = (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'b010);
  assign ar_hs  = s_axi_arvalid & ar_rdy;
  assign r_hs   = s_axi_rvalid & s_axi_rready;
  assign r_last = (r_beat == r_len);
  assign r_next = r_addr + 32'd4;

  // The RAM output register only moves on a new request or an accepted beat,
  // which keeps rdata stable through R stalls.
  assign rd_en  = ar_hs | (r_hs & ~r_last);
  assign rd_idx = ar_hs ? word_idx(s_axi_araddr) : word_idx(r_next);

  assign s_axi_arready = ar_rdy;
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rid     = r_id;
  assign s_axi_rresp   = r_resp;
  assign s_axi_rlast   = s_axi_rvalid & r_last;
  assign s_axi_rdata   = (s_axi_rvalid && r_resp == OKAY) ? r_q : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      ar_rdy  <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_bad   <= 1'b0;
      r_resp  <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          ar_rdy <= 1'b1;
          if (ar_hs) begin
            ar_rdy  <= 1'b0;
            r_id    <= s_axi_arid;
            r_addr  <= s_axi_araddr;
            r_len   <= s_axi_arlen;
            r_bad   <= ar_bad;
            r_beat  <= '0;
            r_resp  <= beat_resp(s_axi_araddr, ar_bad);
            r_state <= R_DATA;
          end
        end
        R_DATA: if (r_hs) begin
          if (r_last) begin
            ar_rdy  <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            r_beat <= r_beat + 8'd1;
            r_addr <= r_next;
            r_resp <= beat_resp(r_next, r_bad);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) r_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: burst writes/reads, strobes, stalls,
// range/burst-type errors and reset during a read burst.
module tb_axi_ram_slave;
  localparam logic [31:0] B     = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic [7:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = '0;
  logic [1:0]  s_axi_awburst = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [3:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic [7:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = '0;
  logic [1:0]  s_axi_arburst = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [3:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;

  axi_ram_slave #(.BASE_ADDR(B), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] wbuf  [256];
  logic [31:0] rbuf  [256];
  logic [1:0]  rrbuf [256];
  logic        rlbuf [256];
  logic [3:0]  rid_seen;
  int          rcnt, rfirst, rlastc;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // All tasks start and end on a negedge; inputs change and outputs are sampled there.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                           input logic [3:0] strb, input logic [2:0] size, input logic [1:0] burst,
                           output logic [1:0] resp, output logic [3:0] rbid);
    int t;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 50) begin @(negedge clk); t++; end
    if (!s_axi_awready) chk("awready_wait", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[i]; s_axi_wstrb = strb;
      s_axi_wlast = (i == int'(len));
      t = 0;
      while (!s_axi_wready && t < 50) begin @(negedge clk); t++; end
      if (!s_axi_wready) chk("wready_wait", s_axi_wready, 1);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin @(negedge clk); t++; end
    if (!s_axi_bvalid) chk("bvalid_wait", s_axi_bvalid, 1);
    resp = s_axi_bresp; rbid = s_axi_bid;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  // mode 0: rready held high; mode 1: rready toggles starting low.
  // abort_at >= 0 asserts rst while that beat is presented and leaves it high.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int mode, input int abort_at);
    int t, cyc;
    logic stalled, hl;
    logic [31:0] hd;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(negedge clk); t++; end
    if (!s_axi_arready) chk("arready_wait", s_axi_arready, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    rcnt = 0; cyc = 0; stalled = 1'b0; hd = '0; hl = 1'b0; rfirst = 0; rlastc = 0;
    while (rcnt <= int'(len) && cyc < 600) begin
      s_axi_rready = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
      if (stalled) begin
        chk("stall_rdata", s_axi_rdata, hd);
        chk("stall_rlast", s_axi_rlast, hl);
      end
      if (abort_at >= 0 && rcnt == abort_at && s_axi_rvalid) begin
        s_axi_rready = 1'b0;
        rst = 1'b1;
        break;
      end
      stalled = s_axi_rvalid && !s_axi_rready;
      hd = s_axi_rdata; hl = s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready) begin
        rbuf[rcnt] = s_axi_rdata; rrbuf[rcnt] = s_axi_rresp; rlbuf[rcnt] = s_axi_rlast;
        rid_seen = s_axi_rid;
        if (rcnt == 0) rfirst = cyc;
        rlastc = cyc;
        rcnt++;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (abort_at < 0) begin
      chk("beat_count", rcnt, int'(len) + 1);
      chk("rvalid_after_last", s_axi_rvalid, 0);
    end
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_arready", s_axi_arready, 1);

    // single-beat write/read with IDs
    wbuf[0] = 32'hDEADBEEF;
    axi_write(B + 32'h10, 8'd0, 4'd3, 4'hF, 3'b010, 2'b01, bresp, bid);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_bid", bid, 4'd3);
    axi_read(B + 32'h10, 8'd0, 4'd3, 3'b010, 2'b01, 0, -1);
    chk("t1_rdata", rbuf[0], 32'hDEADBEEF);
    chk("t1_rlast", rlbuf[0], 1);
    chk("t1_rresp", rrbuf[0], 2'b00);
    chk("t1_rid", rid_seen, 4'd3);

    // 8-beat burst, back-to-back readback
    for (int i = 0; i < 8; i++) wbuf[i] = i;
    axi_write(B + 32'h100, 8'd7, 4'd5, 4'hF, 3'b010, 2'b01, bresp, bid);
    chk("t2_bresp", bresp, 2'b00);
    chk("t2_bid", bid, 4'd5);
    axi_read(B + 32'h100, 8'd7, 4'd9, 3'b010, 2'b01, 0, -1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_rdata", rbuf[i], i);
      chk("t2_rlast", rlbuf[i], (i == 7));
    end
    chk("t2_consecutive", rlastc - rfirst, 7);
    chk("t2_rid", rid_seen, 4'd9);

    // byte strobes
    wbuf[0] = 32'h11223344;
    axi_write(B + 32'h20, 8'd0, 4'd1, 4'hF, 3'b010, 2'b01, bresp, bid);
    wbuf[0] = 32'hAABBCCDD;
    axi_write(B + 32'h20, 8'd0, 4'd1, 4'b0101, 3'b010, 2'b01, bresp, bid);
    axi_read(B + 32'h20, 8'd0, 4'd1, 3'b010, 2'b01, 0, -1);
    chk("t3_strobe", rbuf[0], 32'h11BB33DD);

    // stalled read of beats 2..5
    axi_read(B + 32'h108, 8'd3, 4'd2, 3'b010, 2'b01, 1, -1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_rdata", rbuf[i], i + 2);
      chk("t4_rlast", rlbuf[i], (i == 3));
    end

    // burst crossing the top of RAM
    wbuf[0] = 32'hCAFEF00D; wbuf[1] = 32'h12345678;
    axi_write(B + 32'hFFC, 8'd1, 4'd7, 4'hF, 3'b010, 2'b01, bresp, bid);
    chk("t5_bresp", bresp, 2'b11);
    axi_read(B + 32'hFFC, 8'd1, 4'd7, 3'b010, 2'b01, 0, -1);
    chk("t5_rresp0", rrbuf[0], 2'b00);
    chk("t5_rdata0", rbuf[0], 32'hCAFEF00D);
    chk("t5_rresp1", rrbuf[1], 2'b11);
    chk("t5_rdata1", rbuf[1], 32'h0);
    chk("t5_rlast1", rlbuf[1], 1);

    // unsupported burst type / size, below-base address
    wbuf[0] = 32'h0; wbuf[1] = 32'h0;
    axi_write(B + 32'h20, 8'd1, 4'd4, 4'hF, 3'b010, 2'b00, bresp, bid);
    chk("t6_fixed_bresp", bresp, 2'b10);
    axi_read(B + 32'h20, 8'd0, 4'd4, 3'b001, 2'b01, 0, -1);
    chk("t6_size_rresp", rrbuf[0], 2'b10);
    chk("t6_size_rdata", rbuf[0], 32'h0);
    axi_read(B + 32'h20, 8'd0, 4'd4, 3'b010, 2'b01, 0, -1);
    chk("t6_suppressed", rbuf[0], 32'h11BB33DD);
    axi_read(B - 32'h4, 8'd0, 4'd4, 3'b010, 2'b01, 0, -1);
    chk("t6_below_rresp", rrbuf[0], 2'b11);

    // reset during beat 5 of a 16-beat read
    axi_read(B + 32'h100, 8'd15, 4'd6, 3'b010, 2'b01, 0, 5);
    @(negedge clk);
    chk("t7_rvalid_rst", s_axi_rvalid, 0);
    chk("t7_arready_rst", s_axi_arready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t7_arready_post", s_axi_arready, 1);
    axi_read(B + 32'h100, 8'd7, 4'd6, 3'b010, 2'b01, 0, -1);
    for (int i = 0; i < 8; i++) chk("t7_rdata", rbuf[i], i);
    chk("t7_rlast", rlbuf[7], 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
